ib32bit_adder: RTL and testbench
================================

Name:
ib32bit_adder

Overview:
- Instruction-buffer address incrementer that sits in front of the PC register in the 32-bit processor fetch path.
- Adds an increment amount to the current instruction address and presents the registered next address to the PC.
- Addresses are AWIDTH bits wide and wrap modulo 2^AWIDTH.
- Also reports carry (wrap-around) and an output-valid strobe.

Parameters:
- AWIDTH, 6, width of instruction address, increment and result.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low; synchronous deassert is the integrator's responsibility.
- en  input  1  advance enable; when low, outputs hold.
- inc  input  AWIDTH  unsigned increment amount (normally 1).
- addr  input  AWIDTH  current instruction address.
- addr_out  output  AWIDTH  registered next address (to PC).
- carry_out  output  1  registered carry of the addition; 1 means the result wrapped past 2^AWIDTH-1.
- valid_out  output  1  high for the cycle after an enabled update.

Behaviour:
- Reset:
  - While rst_n=0: addr_out=0, carry_out=0, valid_out=0, immediately and without waiting for clk.
  - First enabled edge after rst_n rises behaves normally.
- Arithmetic:
  - sum = {1'b0,addr} + {1'b0,inc}, computed AWIDTH+1 bits wide, unsigned.
  - Result = sum[AWIDTH-1:0].
  - Carry = sum[AWIDTH].
  - No saturation; wrap is modulo 2^AWIDTH.
- Latency: one clock. Inputs sampled at rising edge N appear on the outputs after edge N.
- en=1 at an edge: addr_out <= result; carry_out <= carry; valid_out <= 1.
- en=0 at an edge: addr_out and carry_out hold their previous values; valid_out <= 0.
- No handshake or backpressure. The consumer samples addr_out whenever valid_out=1.
- Back-to-back updates: every enabled edge produces a new result; throughput is 1 per cycle.
- inc=0: result equals addr, carry=0 (pass-through).
- Maximum case: addr=2^AWIDTH-1, inc=2^AWIDTH-1 gives result 2^AWIDTH-2, carry=1.
- X/Z on inputs while en=0 must not disturb held outputs.
- Reset asserted mid-stream: outputs clear asynchronously; any pending computation is discarded.
- Purely datapath plus registers; no FSM.

Test Plan:
- Reset: hold rst_n=0 with addr=5, inc=1, en=1 -> addr_out=0, carry_out=0, valid_out=0 throughout reset.
- Sweep: rst_n=1, en=1, inc=1, addr=0..31, one value per cycle -> on each following cycle addr_out=addr+1 (1..32), carry_out=0, valid_out=1.
- Wrap: inc=1, addr=62 then 63 ->
  - addr_out=63, carry_out=0;
  - then addr_out=0, carry_out=1.
- Pass-through and large increment:
  - inc=0, addr=17 -> addr_out=17, carry_out=0;
  - inc=63, addr=63 -> addr_out=62, carry_out=1.
- Hold: set addr_out=10, then drop en with addr=40 for 3 cycles -> addr_out stays 10, valid_out=0; re-raise en -> addr_out=41 next cycle.
- Async reset mid-stream: during the sweep, pulse rst_n low between clock edges -> outputs go to 0 immediately; after release, the next enabled edge gives addr_out=addr+1.

Source files
------------

// File: rtl/ib32bit_adder.sv
// ----------------------------------------------------------------------------
// ib32bit_adder
// Instruction-buffer address incrementer in front of the PC register.
// Adds an increment amount to the current instruction address and registers
// the next address, its carry (wrap past 2^AWIDTH-1) and a valid strobe.
//
// Ports:
//   clk        in   1       system clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   en         in   1       advance enable; low holds addr_out/carry_out
//   inc        in   AWIDTH  unsigned increment amount
//   addr       in   AWIDTH  current instruction address
//   addr_out   out  AWIDTH  registered next address
//   carry_out  out  1       registered carry of the addition
//   valid_out  out  1       high for the cycle after an enabled update
// ----------------------------------------------------------------------------
module ib32bit_adder #(
    parameter int unsigned AWIDTH = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [AWIDTH-1:0] inc,
    input  logic [AWIDTH-1:0] addr,
    output logic [AWIDTH-1:0] addr_out,
    output logic              carry_out,
    output logic              valid_out
);

    localparam int unsigned SWIDTH = AWIDTH + 1;

    logic [SWIDTH-1:0] w_sum;
    logic [AWIDTH-1:0] w_result;
    logic              w_carry;

    logic [AWIDTH-1:0] r_addr;
    logic              r_carry;
    logic              r_valid;

    // Zero-extended add so the top bit captures the wrap.
    assign w_sum    = SWIDTH'({1'b0, addr}) + SWIDTH'({1'b0, inc});
    assign w_result = w_sum[AWIDTH-1:0];
    assign w_carry  = w_sum[AWIDTH];

    // Result registers; addr/inc are only looked at when en is high, so
    // unknown inputs during a hold cannot reach the held state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_carry <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            if (en == 1'b1) begin
                r_addr  <= w_result;
                r_carry <= w_carry;
                r_valid <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign addr_out  = r_addr;
    assign carry_out = r_carry;
    assign valid_out = r_valid;

endmodule

// File: tb/tb_ib32bit_adder.sv
// ----------------------------------------------------------------------------
// tb_ib32bit_adder
// Scoreboard bench for ib32bit_adder: the driver pushes the expected result
// of every enabled edge into a queue; a negedge monitor pops and compares
// whenever valid_out is high, and checks held values otherwise.
// ----------------------------------------------------------------------------
module tb_ib32bit_adder;

    localparam int unsigned AW  = 6;
    localparam int          MOD = 1 << AW;

    typedef struct packed {
        logic [AW-1:0] a;
        logic          c;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [AW-1:0] inc;
    logic [AW-1:0] addr;
    logic [AW-1:0] addr_out;
    logic          carry_out;
    logic          valid_out;

    int   total;
    int   bad;
    exp_t sb_q[$];

    // Reference state: value the outputs should hold when not updating.
    int   m_addr;
    int   m_carry;
    int   m_valid;
    logic mon_on;

    ib32bit_adder #(.AWIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .inc       (inc),
        .addr      (addr),
        .addr_out  (addr_out),
        .carry_out (carry_out),
        .valid_out (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the reference model is updated at the edge.
    task automatic step(input logic e, input logic [AW-1:0] a, input logic [AW-1:0] i);
        int s;
        @(negedge clk);
        en   = e;
        addr = a;
        inc  = i;
        @(posedge clk);
        if (e === 1'b1) begin
            s       = int'(a) + int'(i);
            m_addr  = s % MOD;
            m_carry = (s >= MOD) ? 1 : 0;
            m_valid = 1;
            sb_q.push_back('{a: AW'(m_addr), c: (m_carry != 0)});
        end else begin
            m_valid = 0;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_addr"},  int'(addr_out),  0);
        check({tag, "_carry"}, int'(carry_out), 0);
        check({tag, "_valid"}, int'(valid_out), 0);
    endtask

    // Monitor: decoupled from the driver, compares against the queue.
    always @(negedge clk) begin
        exp_t e;
        if (mon_on === 1'b1 && rst_n === 1'b1) begin
            check("valid", int'(valid_out), m_valid);
            if (valid_out === 1'b1) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty: valid_out=1 with no expected entry at %0t", $time);
                end else begin
                    e = sb_q.pop_front();
                    check("addr_out",  int'(addr_out),  int'(e.a));
                    check("carry_out", int'(carry_out), int'(e.c));
                end
            end else begin
                check("hold_addr",  int'(addr_out),  m_addr);
                check("hold_carry", int'(carry_out), m_carry);
            end
        end
    end

    initial begin
        total   = 0;
        bad     = 0;
        m_addr  = 0;
        m_carry = 0;
        m_valid = 0;
        mon_on  = 1'b0;

        // Reset held with live enabled inputs.
        rst_n = 1'b0;
        en    = 1'b1;
        addr  = AW'(5);
        inc   = AW'(1);
        #1;
        check_zero("rst_imm");
        repeat (4) begin
            @(negedge clk);
            check_zero("rst_hold");
        end
        @(posedge clk);
        en = 1'b0;
        #2 rst_n  = 1'b1;
        mon_on = 1'b1;

        // Sweep with an asynchronous reset pulse in the middle.
        for (int k = 0; k < 32; k++) begin
            step(1'b1, AW'(k), AW'(1));
            if (k == 16) begin
                #2 rst_n = 1'b0;
                #1;
                check_zero("rst_mid");
                sb_q.delete();
                m_addr  = 0;
                m_carry = 0;
                m_valid = 0;
                #1 rst_n = 1'b1;
            end
        end

        // Wrap boundary.
        step(1'b1, AW'(62), AW'(1));
        step(1'b1, AW'(63), AW'(1));

        // Pass-through and maximum increment.
        step(1'b1, AW'(17), AW'(0));
        step(1'b1, AW'(63), AW'(63));

        // Hold: unknown inputs while disabled must not disturb outputs.
        step(1'b1, AW'(9), AW'(1));
        repeat (3) step(1'b0, AW'(40), AW'(1));
        step(1'b0, 'x, 'x);
        step(1'b1, AW'(40), AW'(1));

        // Randomized traffic.
        for (int k = 0; k < 300; k++) begin
            step(($urandom_range(0, 3) != 0), AW'($urandom), AW'($urandom));
        end

        step(1'b0, AW'(0), AW'(0));
        repeat (2) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
